alu_seq_core: RTL

- Parametrised successor to the team's 3-bit/2-bit combinational user-module ALU.
- Operands are WIDTH bits wide. Operations are issued through a valid/ready handshake and results are registered.
- Includes an accumulator register that can replace operand A, so operations can be chained.
- Has an optional iterative multi-cycle multiply. Sits between the user I/O wrapper and any downstream consumer of results.

---
 rtl/alu_seq_core.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_core.sv
// Sequential WIDTH-bit ALU with valid/ready handshake, registered flags and a chaining accumulator.
// Define ALU_MUL_EN to add the iterative shift-add multiply on opcode 1000; otherwise that opcode is illegal.
module alu_seq_core #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_err;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   shl_full;
    logic [WIDTH:0]   shr_full;

    assign op_a = acc_sel ? acc_q : a;

    // The extra bit of each shift vector catches the last bit shifted out; amounts beyond WIDTH flush it to 0.
    assign add_full = {1'b0, op_a} + {1'b0, b};
    assign shl_full = {1'b0, op_a} << b;
    assign shr_full = {op_a, 1'b0} >> b;

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mul_cand_q, mul_cand_d;
    logic [WIDTH-1:0]   mul_plier_q, mul_plier_d;
    logic [2*WIDTH-1:0] mul_prod_q, mul_prod_d;
    logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    logic [2*WIDTH-1:0] mul_prod_nxt;

    assign mul_prod_nxt = mul_prod_q + (mul_plier_q[0] ? mul_cand_q : '0);
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        unique case (op)
            OP_ADD:  begin alu_res = add_full[WIDTH-1:0]; alu_carry = add_full[WIDTH]; end
            OP_SUB:  begin alu_res = op_a - b;            alu_carry = (op_a < b);      end
            OP_AND:  alu_res = op_a & b;
            OP_OR:   alu_res = op_a | b;
            OP_XOR:  alu_res = op_a ^ b;
            OP_SHL:  begin alu_res = shl_full[WIDTH-1:0]; alu_carry = shl_full[WIDTH]; end
            OP_SHR:  begin alu_res = shr_full[WIDTH:1];   alu_carry = shr_full[0];     end
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < b)};
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        acc_d    = acc_q;
`ifdef ALU_MUL_EN
        mul_cand_d  = mul_cand_q;
        mul_plier_d = mul_plier_q;
        mul_prod_d  = mul_prod_q;
        mul_cnt_d   = mul_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_MUL_EN
                    if (op == OP_MUL) begin
                        state_d     = S_BUSY;
                        mul_cand_d  = {{WIDTH{1'b0}}, op_a};
                        mul_plier_d = b;
                        mul_prod_d  = '0;
                        mul_cnt_d   = '0;
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                        carry_d  = alu_carry;
                        zero_d   = (alu_res == '0);
                        err_d    = alu_err;
                        if (!alu_err) acc_d = alu_res;
                    end
                end
            end
`ifdef ALU_MUL_EN
            S_BUSY: begin
                mul_prod_d  = mul_prod_nxt;
                mul_cand_d  = mul_cand_q << 1;
                mul_plier_d = mul_plier_q >> 1;
                mul_cnt_d   = mul_cnt_q + 1'b1;
                if (mul_cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = mul_prod_nxt[WIDTH-1:0];
                    carry_d  = |mul_prod_nxt[2*WIDTH-1:WIDTH];
                    zero_d   = (mul_prod_nxt[WIDTH-1:0] == '0);
                    err_d    = 1'b0;
                    acc_d    = mul_prod_nxt[WIDTH-1:0];
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= ACC_INIT;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values together.
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cand_q  <= '0;
            mul_plier_q <= '0;
            mul_prod_q  <= '0;
            mul_cnt_q   <= '0;
        end else begin
            mul_cand_q  <= mul_cand_d;
            mul_plier_q <= mul_plier_d;
            mul_prod_q  <= mul_prod_d;
            mul_cnt_q   <= mul_cnt_d;
        end
    end
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign acc       = acc_q;

endmodule
